// File: rtl/pipe_regs_pkg.sv
// Shared constants for the five-stage pipeline registers: status and icode
// encodings, register-ID sentinel, bundle widths/layouts and bubble values.
package pipe_regs_pkg;

    localparam logic [3:0] STAT_AOK = 4'b0001;
    localparam logic [3:0] STAT_HLT = 4'b0010;
    localparam logic [3:0] STAT_ADR = 4'b0100;
    localparam logic [3:0] STAT_INS = 4'b1000;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int unsigned F_W = 64;
    localparam int unsigned D_W = 148;
    localparam int unsigned E_W = 184;
    localparam int unsigned M_W = 145;
    localparam int unsigned W_W = 144;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_bundle_t;

    // valB carries only its low 28 bits; srcA/srcB occupy the remaining tail
    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [27:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } e_bundle_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } m_bundle_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } w_bundle_t;

    localparam logic [F_W-1:0] F_BUBBLE = '0;
    localparam logic [D_W-1:0] D_BUBBLE = {STAT_AOK, INOP, 4'h0, RNONE, RNONE, 64'h0, 64'h0};
    localparam logic [E_W-1:0] E_BUBBLE = {STAT_AOK, INOP, 4'h0, 64'h0, 64'h0, 28'h0,
                                           RNONE, RNONE, RNONE, RNONE};
    localparam logic [M_W-1:0] M_BUBBLE = {STAT_AOK, INOP, 1'b0, 64'h0, 64'h0, RNONE, RNONE};
    localparam logic [W_W-1:0] W_BUBBLE = {STAT_AOK, INOP, 64'h0, 64'h0, RNONE, RNONE};

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register with optional stall (hold) and bubble (inject NOP).
// Priority per edge: rst > stall > bubble > load; reset loads BUBBLE_VAL.
module pipe_stage_reg #(
    parameter int unsigned     WIDTH      = 64,
    parameter bit              HAS_STALL  = 1'b1,
    parameter bit              HAS_BUBBLE = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             bubble,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic stall_en;
    logic bubble_en;

    assign stall_en  = HAS_STALL && stall;
    assign bubble_en = HAS_BUBBLE && bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= BUBBLE_VAL;
        end else if (stall_en) begin
            dout <= dout;
        end else if (bubble_en) begin
            dout <= BUBBLE_VAL;
        end else begin
            dout <= din;
        end
    end

endmodule

// File: rtl/pipe_regs.sv
// F/D/E/M/W pipeline registers with sticky illegal-control flag.
// Define PIPE_PERF_EN to add saturating stall_cnt/bubble_cnt outputs.
module pipe_regs
    import pipe_regs_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [F_W-1:0] f_predPC,
    input  logic [D_W-1:0] d_in,
    input  logic [E_W-1:0] e_in,
    input  logic [M_W-1:0] m_in,
    input  logic [W_W-1:0] w_in,
    input  logic           F_stall,
    input  logic           D_stall,
    input  logic           D_bubble,
    input  logic           E_bubble,
    input  logic           M_bubble,
    input  logic           W_stall,
    output logic [F_W-1:0] F_predPC,
    output logic [D_W-1:0] D_out,
    output logic [E_W-1:0] E_out,
    output logic [M_W-1:0] M_out,
    output logic [W_W-1:0] W_out,
    output logic           ctl_err
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [31:0]    bubble_cnt
`endif
);

    pipe_stage_reg #(.WIDTH(F_W), .HAS_STALL(1'b1), .HAS_BUBBLE(1'b0), .BUBBLE_VAL(F_BUBBLE)) u_f (
        .clk(clk), .rst(rst), .stall(F_stall), .bubble(1'b0), .din(f_predPC), .dout(F_predPC)
    );

    pipe_stage_reg #(.WIDTH(D_W), .HAS_STALL(1'b1), .HAS_BUBBLE(1'b1), .BUBBLE_VAL(D_BUBBLE)) u_d (
        .clk(clk), .rst(rst), .stall(D_stall), .bubble(D_bubble), .din(d_in), .dout(D_out)
    );

    pipe_stage_reg #(.WIDTH(E_W), .HAS_STALL(1'b0), .HAS_BUBBLE(1'b1), .BUBBLE_VAL(E_BUBBLE)) u_e (
        .clk(clk), .rst(rst), .stall(1'b0), .bubble(E_bubble), .din(e_in), .dout(E_out)
    );

    pipe_stage_reg #(.WIDTH(M_W), .HAS_STALL(1'b0), .HAS_BUBBLE(1'b1), .BUBBLE_VAL(M_BUBBLE)) u_m (
        .clk(clk), .rst(rst), .stall(1'b0), .bubble(M_bubble), .din(m_in), .dout(M_out)
    );

    pipe_stage_reg #(.WIDTH(W_W), .HAS_STALL(1'b1), .HAS_BUBBLE(1'b0), .BUBBLE_VAL(W_BUBBLE)) u_w (
        .clk(clk), .rst(rst), .stall(W_stall), .bubble(1'b0), .din(w_in), .dout(W_out)
    );

    // Stall+bubble on D resolves to a hold inside u_d; here it is only flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_err <= 1'b0;
        end else if (D_stall && D_bubble) begin
            ctl_err <= 1'b1;
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if ((F_stall || D_stall || W_stall) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((D_bubble || E_bubble || M_bubble) && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_regs.sv
// Directed bench for pipe_regs with a reference model feeding a scoreboard queue.
// Perf-counter checks compile only when PIPE_PERF_EN is defined.
module tb_pipe_regs;
    import pipe_regs_pkg::*;

    logic           clk;
    logic           rst;
    logic [F_W-1:0] f_predPC;
    logic [D_W-1:0] d_in;
    logic [E_W-1:0] e_in;
    logic [M_W-1:0] m_in;
    logic [W_W-1:0] w_in;
    logic           F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [F_W-1:0] F_predPC;
    logic [D_W-1:0] D_out;
    logic [E_W-1:0] E_out;
    logic [M_W-1:0] M_out;
    logic [W_W-1:0] W_out;
    logic           ctl_err;
`ifdef PIPE_PERF_EN
    logic [31:0]    stall_cnt;
    logic [31:0]    bubble_cnt;
`endif

    pipe_regs dut (
        .clk(clk), .rst(rst), .f_predPC(f_predPC), .d_in(d_in), .e_in(e_in),
        .m_in(m_in), .w_in(w_in), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .F_predPC(F_predPC), .D_out(D_out), .E_out(E_out), .M_out(M_out), .W_out(W_out),
        .ctl_err(ctl_err)
`ifdef PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [F_W-1:0] f;
        logic [D_W-1:0] d;
        logic [E_W-1:0] e;
        logic [M_W-1:0] m;
        logic [W_W-1:0] w;
        logic           err;
        logic [31:0]    sc;
        logic [31:0]    bc;
    } snap_t;

    snap_t model;
    snap_t exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic rand_inputs();
        logic [255:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        f_predPC = r[63:0];
        d_in     = r[147:0];
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        e_in     = r[183:0];
        m_in     = r[244:100];
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        w_in     = r[143:0];
    endtask

    // Drive one cycle of controls, predict the post-edge state, then compare.
    task automatic cycle(input logic r, input logic fs, input logic ds, input logic db,
                         input logic eb, input logic mb, input logic ws);
        snap_t got;
        snap_t exp;
        rst = r; F_stall = fs; D_stall = ds; D_bubble = db;
        E_bubble = eb; M_bubble = mb; W_stall = ws;
        if (r) begin
            model = '{f: '0, d: D_BUBBLE, e: E_BUBBLE, m: M_BUBBLE, w: W_BUBBLE,
                      err: 1'b0, sc: 32'd0, bc: 32'd0};
        end else begin
            if (!fs) model.f = f_predPC;
            if (!ds) model.d = db ? D_BUBBLE : d_in;
            model.e = eb ? E_BUBBLE : e_in;
            model.m = mb ? M_BUBBLE : m_in;
            if (!ws) model.w = w_in;
            if (ds && db) model.err = 1'b1;
            if ((fs || ds || ws) && model.sc != 32'hFFFFFFFF) model.sc = model.sc + 32'd1;
            if ((db || eb || mb) && model.bc != 32'hFFFFFFFF) model.bc = model.bc + 32'd1;
        end
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        got.f = F_predPC; got.d = D_out; got.e = E_out; got.m = M_out; got.w = W_out;
        got.err = ctl_err;
        chk("F_predPC", 256'(got.f), 256'(exp.f));
        chk("D_out", 256'(got.d), 256'(exp.d));
        chk("E_out", 256'(got.e), 256'(exp.e));
        chk("M_out", 256'(got.m), 256'(exp.m));
        chk("W_out", 256'(got.w), 256'(exp.w));
        chk("ctl_err", 256'(got.err), 256'(exp.err));
`ifdef PIPE_PERF_EN
        chk("stall_cnt", 256'(stall_cnt), 256'(exp.sc));
        chk("bubble_cnt", 256'(bubble_cnt), 256'(exp.bc));
`endif
    endtask

    initial begin
        logic [F_W-1:0] pc_saved;
        logic [M_W-1:0] m_saved;
        logic [D_W-1:0] d_saved;
        logic [W_W-1:0] w_saved;
        logic [6:0]     ctl;

        model = '0;
        rand_inputs();
        rst = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        E_bubble = 1'b0; M_bubble = 1'b0; W_stall = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("rst_F_predPC", 256'(F_predPC), 256'(0));
        chk("rst_E_icode", 256'(E_out[179:176]), 256'(4'h1));
        chk("rst_W_dstE", 256'(W_out[7:4]), 256'(4'hF));
        chk("rst_ctl_err", 256'(ctl_err), 256'(0));

        // Plain loads
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cycle(0, 0, 0, 0, 0, 0, 0);
        end

        // Load-use style stall: F/D hold, E bubbles
        rand_inputs();
        d_in[143:140] = 4'h5;
        cycle(0, 0, 0, 0, 0, 0, 0);
        pc_saved = F_predPC;
        rand_inputs();
        cycle(0, 1, 1, 0, 1, 0, 0);
        chk("stall_D_icode", 256'(D_out[143:140]), 256'(4'h5));
        chk("stall_E_bubble", 256'(E_out), 256'(E_BUBBLE));
        chk("stall_F_hold", 256'(F_predPC), 256'(pc_saved));

        // Mispredict: D and E bubble, M loads
        rand_inputs();
        e_in[179:176] = 4'h6;
        m_saved = m_in;
        cycle(0, 0, 0, 1, 1, 0, 0);
        chk("mispred_D", 256'(D_out), 256'(D_BUBBLE));
        chk("mispred_E", 256'(E_out), 256'(E_BUBBLE));
        chk("mispred_M", 256'(M_out), 256'(m_saved));

        // Illegal D_stall+D_bubble: hold and flag, flag sticky
        rand_inputs();
        cycle(0, 0, 0, 0, 0, 0, 0);
        d_saved = D_out;
        rand_inputs();
        cycle(0, 0, 1, 1, 0, 0, 0);
        chk("illegal_D_hold", 256'(D_out), 256'(d_saved));
        chk("illegal_err", 256'(ctl_err), 256'(1));
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            cycle(0, 0, 0, 0, 0, 0, 0);
        end
        chk("err_sticky", 256'(ctl_err), 256'(1));

        // Random control mix, no reset
        for (int i = 0; i < 24; i++) begin
            rand_inputs();
            ctl = 7'($urandom);
            cycle(0, ctl[0], ctl[1], ctl[2], ctl[3], ctl[4], ctl[5]);
        end

        // Reset overrides stall and bubble on the same edge
        rand_inputs();
        cycle(1, 1, 1, 1, 1, 1, 1);
        chk("rst_over_D", 256'(D_out), 256'(D_BUBBLE));
        chk("rst_over_err", 256'(ctl_err), 256'(0));

        // W freeze across 10 cycles
        rand_inputs();
        cycle(0, 0, 0, 0, 0, 0, 0);
        w_saved = W_out;
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            cycle(0, 0, 0, 0, 0, 0, 1);
            chk("W_freeze", 256'(W_out), 256'(w_saved));
        end
`ifdef PIPE_PERF_EN
        chk("stall_cnt_10", 256'(stall_cnt), 256'(32'd10));

        // Saturation of bubble_cnt from a forced near-max value
        force dut.bubble_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.bubble_cnt_q;
        model.bc = 32'hFFFFFFFE;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cycle(0, 0, 0, 0, 0, 1, 0);
        end
        chk("bubble_sat", 256'(bubble_cnt), 256'(32'hFFFFFFFF));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
